// File: rtl/riscv_inst_encoder.sv
// RISC-V instruction encoder: packs R/I/S/B/U/J fields into a 32-bit word behind a 2-entry FIFO.
// Optional immediate range checking is enabled by defining ENCODER_RANGE_CHECK_EN.
module riscv_inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  function automatic logic [31:0] pack_inst(
    input logic [2:0]  fmt,
    input logic [6:0]  opc,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    case (fmt)
      FMT_R:   w = {f7, rs2, rs1, f3, rd, opc};
      FMT_I:   w = {imm[11:0], rs1, f3, rd, opc};
      FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      FMT_U:   w = {imm[31:12], rd, opc};
      FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

`ifdef ENCODER_RANGE_CHECK_EN
  // Flags immediates that cannot be represented exactly in the chosen format.
  function automatic logic range_bad(input logic [2:0] fmt, input logic [31:0] imm);
    logic signed [31:0] s;
    logic               bad;
    s = $signed(imm);
    case (fmt)
      FMT_I, FMT_S: bad = (s < -32'sd2048) || (s > 32'sd2047);
      FMT_B:        bad = (s < -32'sd4096) || (s > 32'sd4094) || imm[0];
      FMT_J:        bad = (s < -32'sd1048576) || (s > 32'sd1048574) || imm[0];
      FMT_U:        bad = (imm[11:0] != 12'h000);
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] head_inst_q, head_inst_d, tail_inst_q, tail_inst_d;
  logic        head_err_q, head_err_d, tail_err_q, tail_err_d;
  logic [15:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;
  logic [31:0] new_inst_s;
  logic        new_err_s;
  logic        push_s, pop_s;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_inst  = head_inst_q;
  assign out_err   = head_err_q;
  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Encode the incoming request; formats 6 and 7 always yield a zero word with error.
  always_comb begin
    new_inst_s = 32'h0000_0000;
    new_err_s  = 1'b1;
    if (in_fmt <= FMT_J) begin
      new_inst_s = pack_inst(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                             in_funct3, in_funct7, in_imm);
`ifdef ENCODER_RANGE_CHECK_EN
      new_err_s  = range_bad(in_fmt, in_imm);
`else
      new_err_s  = 1'b0;
`endif
    end else begin
      new_inst_s = 32'h0000_0000;
      new_err_s  = 1'b1;
    end
  end

  // FIFO next state: head is always the output slot, tail only holds the second entry.
  always_comb begin
    cnt_d       = cnt_q;
    head_inst_d = head_inst_q;
    head_err_d  = head_err_q;
    tail_inst_d = tail_inst_q;
    tail_err_d  = tail_err_q;
    case (cnt_q)
      2'd0: begin
        if (push_s) begin
          head_inst_d = new_inst_s;
          head_err_d  = new_err_s;
          cnt_d       = 2'd1;
        end else begin
          cnt_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          head_inst_d = new_inst_s;
          head_err_d  = new_err_s;
        end else if (push_s) begin
          tail_inst_d = new_inst_s;
          tail_err_d  = new_err_s;
          cnt_d       = 2'd2;
        end else if (pop_s) begin
          cnt_d = 2'd0;
        end else begin
          cnt_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_inst_d = tail_inst_q;
          head_err_d  = tail_err_q;
          cnt_d       = 2'd1;
        end else begin
          cnt_d = 2'd2;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // Accept counter wraps; error counter saturates.
  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push_s) begin
      enc_cnt_d = enc_cnt_q + 16'd1;
      if (new_err_s && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      enc_cnt_d = enc_cnt_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 2'd0;
      head_inst_q <= 32'h0000_0000;
      head_err_q  <= 1'b0;
      tail_inst_q <= 32'h0000_0000;
      tail_err_q  <= 1'b0;
      enc_cnt_q   <= 16'h0000;
      err_cnt_q   <= 16'h0000;
    end else begin
      cnt_q       <= cnt_d;
      head_inst_q <= head_inst_d;
      head_err_q  <= head_err_d;
      tail_inst_q <= tail_inst_d;
      tail_err_q  <= tail_err_d;
      enc_cnt_q   <= enc_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_riscv_inst_encoder.sv
// Directed self-checking bench for riscv_inst_encoder; expectations follow ENCODER_RANGE_CHECK_EN.
module tb_riscv_inst_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [15:0] exp_enc = 16'h0000;
  logic [15:0] exp_errc = 16'h0000;
  logic        rc;

  riscv_inst_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Single request with out_ready high: accept, check one cycle later, then drained.
  task automatic do_one(input string tag, input logic [2:0] fmt, input logic [6:0] opc,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] e_inst, input logic e_err);
    drive(fmt, opc, rd, rs1, rs2, f3, f7, imm);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    exp_enc = exp_enc + 16'd1;
    if (e_err && exp_errc != 16'hFFFF) exp_errc = exp_errc + 16'd1;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_inst"}, out_inst, e_inst);
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, e_err});
    chk({tag, "_enc_count"}, {16'd0, enc_count}, {16'd0, exp_enc});
    chk({tag, "_err_count"}, {16'd0, err_count}, {16'd0, exp_errc});
    @(posedge clk); #1;
    chk({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_inst", out_inst, 32'h0000_0000);
    chk("rst_enc", {16'd0, enc_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_one("addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    do_one("add", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
    do_one("sw", 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
    do_one("beq_m4", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 32'hFE20_8EE3, 1'b0);
    do_one("jal_2048", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 1'b0);
    do_one("lui", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
`ifdef ENCODER_RANGE_CHECK_EN
    rc = 1'b1;
`else
    rc = 1'b0;
`endif
    do_one("addi_2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, rc);
    do_one("beq_odd", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, rc);
    do_one("lui_low", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, rc);
    do_one("fmt7", 3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'd1, 32'h0000_0000, 1'b1);
    do_one("fmt6", 3'd6, 7'h33, 5'd2, 5'd2, 5'd2, 3'd2, 7'd2, 32'd2, 32'h0000_0000, 1'b1);

    // Backpressure: three back-to-back requests with the consumer stalled.
    out_ready = 1'b0;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_rdy_after1", {31'd0, in_ready}, 32'd1);
    chk("bp_head_a", out_inst, 32'h0010_0093);
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    @(posedge clk); #1;
    chk("bp_rdy_after2", {31'd0, in_ready}, 32'd0);
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    @(posedge clk); #1;
    chk("bp_full_hold", out_inst, 32'h0010_0093);
    chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drain_b", out_inst, 32'h0020_0093);
    chk("bp_rdy_after_pop", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_drain_c", out_inst, 32'h0030_0093);
    exp_enc = exp_enc + 16'd3;
    chk("bp_enc", {16'd0, enc_count}, {16'd0, exp_enc});
    @(posedge clk); #1;
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with two entries queued.
    out_ready = 1'b0;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_full", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_enc", {16'd0, enc_count}, 32'd0);
    chk("mid_rst_err", {16'd0, err_count}, 32'd0);
    chk("mid_rst_inst", out_inst, 32'h0000_0000);
    #1;
    rst = 1'b0;
    exp_enc = 16'h0000;
    exp_errc = 16'h0000;
    do_one("post_rst", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);

    // Stream illegal-format requests: enc_count wraps, err_count saturates.
    out_ready = 1'b1;
    drive(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("wrap_enc_ffff", {16'd0, enc_count}, 32'h0000_FFFF);
    chk("sat_err_ffff", {16'd0, err_count}, 32'h0000_FFFE);
    @(posedge clk); #1;
    chk("sat_err_max", {16'd0, err_count}, 32'h0000_FFFF);
    chk("wrap_enc_0", {16'd0, enc_count}, 32'h0000_0000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("wrap_enc_1", {16'd0, enc_count}, 32'h0000_0001);
    chk("sat_err_hold", {16'd0, err_count}, 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
